spike_step_scheduler: RTL and testbench

SPIKE_STEP_SCHEDULER -- requirements
Module: spike_step_scheduler

---
 rtl/spike_step_scheduler_if.sv | 11 +
 rtl/spike_step_scheduler.sv | 134 +++++++++++++
 tb/tb_spike_step_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/spike_step_scheduler_if.sv
// Spike event handshake between the step scheduler (master) and its event consumer.
interface spike_step_scheduler_if #(
  parameter int ID_W = 3
);
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/spike_step_scheduler.sv
// Time-step generator for a neuron array plus a round-robin spike event serializer.
// One pending-bit cell per neuron; the top owns the FSM, arbiter and event register.
module spike_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic spike,
  input  logic clr,
  output logic pend,
  output logic lost
);
  // A re-spike on the handshake edge re-arms the bit instead of counting as lost.
  assign lost = active & spike & pend & ~clr;

  always_ff @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else     pend <= (pend & ~clr) | (active & spike);
  end
endmodule

module spike_step_scheduler #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [15:0]                   step_period,
  input  logic [N-1:0]                  spike_in,
  output logic                          time_step,
  spike_step_scheduler_if.master        evt,
  output logic                          overflow,
  output logic                          busy,
  output logic [15:0]                   step_count
);
  typedef enum logic [1:0] {IDLE, COUNT, STEP, DRAIN} state_t;

  state_t          state;
  logic [15:0]     period, cnt;
  logic [ID_W-1:0] ptr, win_id;
  logic [N-1:0]    pend, lost, clr;
  logic            active, hs, win_found;

  assign busy   = (state != IDLE);
  assign active = (state == COUNT) || (state == STEP);
  assign hs     = evt.evt_valid & evt.evt_ready;

  always_comb begin
    clr = '0;
    if (hs) clr[evt.evt_id] = 1'b1;
  end

  // Round-robin: first pending bit strictly after ptr, wrapping modulo N.
  always_comb begin
    win_id    = ptr;
    win_found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      if (!win_found && pend[(int'(ptr) + off) % N]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr) + off) % N);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cell
    spike_pend_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .active (active),
      .spike  (spike_in[i]),
      .clr    (clr[i]),
      .pend   (pend[i]),
      .lost   (lost[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      period        <= 16'd4;
      cnt           <= '0;
      time_step     <= 1'b0;
      step_count    <= '0;
      overflow      <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      ptr           <= ID_W'(N - 1);
    end else begin
      time_step <= 1'b0;
      if (|lost) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            period     <= (step_period < 16'd4) ? 16'd4 : step_period;
            cnt        <= '0;
            step_count <= '0;
            overflow   <= 1'b0;
            state      <= COUNT;
          end
        end
        COUNT: begin
          if (stop) begin
            state <= DRAIN;
          end else if (cnt == period - 16'd2) begin
            // Pulse and count land together so step_count tracks time_step.
            state      <= STEP;
            time_step  <= 1'b1;
            step_count <= step_count + 16'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STEP: begin
          cnt   <= '0;
          state <= stop ? DRAIN : COUNT;
        end
        DRAIN: begin
          if (pend == '0 && !evt.evt_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (hs) begin
        evt.evt_valid <= 1'b0;
        ptr           <= evt.evt_id;
      end else if (!evt.evt_valid && pend != '0) begin
        evt.evt_id    <= win_id;
        evt.evt_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spike_step_scheduler.sv
// Directed bench for spike_step_scheduler: step timing, clamp, round-robin, overflow, drain, reset.
module tb_spike_step_scheduler;
  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [15:0] step_period;
  logic [7:0]  spike_in;
  logic        time_step, overflow, busy;
  logic [15:0] step_count;
  int          total = 0;
  int          bad   = 0;

  spike_step_scheduler_if #(.ID_W(3)) evt_if ();

  spike_step_scheduler #(.N(8), .ID_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .step_period (step_period),
    .spike_in    (spike_in),
    .time_step   (time_step),
    .evt         (evt_if),
    .overflow    (overflow),
    .busy        (busy),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step_period = 16'd0; spike_in = '0;
    evt_if.evt_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ts", time_step, 0);
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_id", evt_if.evt_id, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_stepcnt", step_count, 0);
    rst = 1'b0;

    // stop in IDLE is ignored
    stop = 1'b1; tick(); stop = 1'b0;
    chk("idle_stop_busy", busy, 0);

    // P=5 with simultaneous start+stop (start wins); stray start mid-run ignored
    step_period = 16'd5; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("p5_busy", busy, 1);
    for (int c = 1; c <= 14; c++) begin
      start       = (c == 6);
      step_period = (c == 6) ? 16'd9 : 16'd5;
      tick();
      chk($sformatf("p5_ts_c%0d", c), time_step, (c == 4 || c == 9 || c == 14));
    end
    start = 1'b0; step_period = 16'd5;
    chk("p5_stepcnt", step_count, 3);
    chk("p5_busy_run", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("p5_stop_ts", time_step, 0);
    chk("p5_stop_busy", busy, 1);
    tick();
    chk("p5_idle", busy, 0);
    chk("p5_stepcnt_hold", step_count, 3);

    // step_period=2 clamps to 4
    step_period = 16'd2; start = 1'b1; tick(); start = 1'b0;
    chk("p2_stepcnt_clr", step_count, 0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("p2_ts_c%0d", c), time_step, (c % 4 == 3));
    end
    chk("p2_stepcnt", step_count, 3);
    stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("p2_idle", busy, 0);

    // round-robin: 0x81 -> 0 then 7; 0x03 -> 0 then 1
    step_period = 16'd100; evt_if.evt_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    spike_in = 8'h81; tick(); spike_in = '0;
    tick(); chk("rr_a_valid", evt_if.evt_valid, 1); chk("rr_a_id", evt_if.evt_id, 0);
    tick(); chk("rr_a_gap", evt_if.evt_valid, 0);
    tick(); chk("rr_b_valid", evt_if.evt_valid, 1); chk("rr_b_id", evt_if.evt_id, 7);
    tick(); chk("rr_b_done", evt_if.evt_valid, 0);
    spike_in = 8'h03; tick(); spike_in = '0;
    tick(); chk("rr_c_valid", evt_if.evt_valid, 1); chk("rr_c_id", evt_if.evt_id, 0);
    tick(); chk("rr_c_gap", evt_if.evt_valid, 0);
    tick(); chk("rr_d_valid", evt_if.evt_valid, 1); chk("rr_d_id", evt_if.evt_id, 1);
    tick(); chk("rr_d_done", evt_if.evt_valid, 0);

    // backpressure hold and overflow on re-spike of neuron 3
    evt_if.evt_ready = 1'b0;
    spike_in = 8'h08; tick(); spike_in = '0;
    tick(); chk("bp_valid", evt_if.evt_valid, 1); chk("bp_id", evt_if.evt_id, 3);
    chk("bp_ovf0", overflow, 0);
    spike_in = 8'h08; tick(); spike_in = '0;
    chk("bp_ovf1", overflow, 1);
    tick(); tick();
    chk("bp_hold_valid", evt_if.evt_valid, 1); chk("bp_hold_id", evt_if.evt_id, 3);
    evt_if.evt_ready = 1'b1; tick();
    chk("bp_hs", evt_if.evt_valid, 0);
    tick(); tick();
    chk("bp_single", evt_if.evt_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // stop with neurons 2 and 5 pending; ptr=3 so 5 goes first
    evt_if.evt_ready = 1'b0;
    spike_in = 8'h24; tick(); spike_in = '0;
    stop = 1'b1; tick(); stop = 1'b0; evt_if.evt_ready = 1'b1;
    chk("dr_busy", busy, 1); chk("dr_v1", evt_if.evt_valid, 1); chk("dr_id1", evt_if.evt_id, 5);
    tick(); chk("dr_hs1", evt_if.evt_valid, 0);
    tick(); chk("dr_v2", evt_if.evt_valid, 1); chk("dr_id2", evt_if.evt_id, 2);
    tick(); chk("dr_hs2", evt_if.evt_valid, 0); chk("dr_busy_hs", busy, 1);
    tick(); chk("dr_idle", busy, 0); chk("dr_ts", time_step, 0);
    chk("dr_stepcnt", step_count, 0);

    // handshake coinciding with re-spike keeps the bit, no overflow; start clears overflow
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_ovf_clr", overflow, 0);
    spike_in = 8'h02; tick(); spike_in = '0;
    tick(); chk("rs_v1", evt_if.evt_valid, 1); chk("rs_id1", evt_if.evt_id, 1);
    spike_in = 8'h02; tick(); spike_in = '0;
    chk("rs_hs", evt_if.evt_valid, 0); chk("rs_ovf", overflow, 0);
    tick(); chk("rs_v2", evt_if.evt_valid, 1); chk("rs_id2", evt_if.evt_id, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("rs_hs2", evt_if.evt_valid, 0);
    tick(); chk("rs_idle", busy, 0);

    // reset aborts an in-flight event and restores id-0 priority
    start = 1'b1; tick(); start = 1'b0; evt_if.evt_ready = 1'b0;
    spike_in = 8'h10; tick(); spike_in = '0;
    tick(); chk("ra_valid", evt_if.evt_valid, 1); chk("ra_id", evt_if.evt_id, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ra_rst_valid", evt_if.evt_valid, 0); chk("ra_rst_id", evt_if.evt_id, 0);
    chk("ra_rst_busy", busy, 0); chk("ra_rst_ts", time_step, 0);
    tick(); tick();
    chk("ra_no_replay", evt_if.evt_valid, 0);
    start = 1'b1; tick(); start = 1'b0; evt_if.evt_ready = 1'b1;
    spike_in = 8'h81; tick(); spike_in = '0;
    tick(); chk("ra_first_v", evt_if.evt_valid, 1); chk("ra_first_id", evt_if.evt_id, 0);
    tick(); tick(); chk("ra_second_id", evt_if.evt_id, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
